// File: rtl/dram_write_scheduler_pkg.sv
// Shared types and constants for the DRAM write scheduler and its ring address generator.
// Burst geometry matches the AXI DRAM writer.
package dram_write_scheduler_pkg;

  localparam int unsigned BURST_BYTES = 128;
  localparam int unsigned BURST_SHIFT = $clog2(BURST_BYTES);
  localparam int unsigned NBURST_W    = 32 - BURST_SHIFT;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT_B = 2'd2,
    ST_NEXT   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/dram_ring_addr_gen.sv
// Ring-buffer index and start-address tracker.
// load_i restarts at buffer 0; advance_i steps to the next buffer and wraps after NBUF-1.
module dram_ring_addr_gen #(
  parameter int NBUF = 3,
  parameter int IDXW = 4
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  input  logic            load_i,
  input  logic            advance_i,
  input  logic [31:0]     base_i,
  input  logic [31:0]     stride_i,
  output logic [IDXW-1:0] idx_o,
  output logic [31:0]     addr_o
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBUF - 1);

  logic [IDXW-1:0] idx_q, idx_d;
  logic [31:0]     addr_q, addr_d;

  always_comb begin
    idx_d  = idx_q;
    addr_d = addr_q;
    if (load_i) begin
      idx_d  = '0;
      addr_d = base_i;
    end else if (advance_i) begin
      if (idx_q == LAST_IDX) begin
        idx_d  = '0;
        addr_d = base_i;
      end else begin
        idx_d  = idx_q + IDXW'(1);
        addr_d = addr_q + stride_i;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      idx_q  <= '0;
      addr_q <= '0;
    end else begin
      idx_q  <= idx_d;
      addr_q <= addr_d;
    end
  end

  assign idx_o  = idx_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/dram_write_scheduler.sv
// Splits a multi-frame capture command into single-frame writer configurations,
// counts B responses per frame and publishes each completed ring buffer index.
//
// state   | meaning
// IDLE    | no run active; waits for CTRL_START
// ISSUE   | waits for writer CONFIG_READY, then fires a one-cycle CONFIG_VALID
// WAIT_B  | counts B beats until the frame's burst count has landed
// NEXT    | frame complete; advance ring, decide continue or finish
module dram_write_scheduler
  import dram_write_scheduler_pkg::*;
#(
  parameter int NBUF = 3,
  parameter int IDXW = 4
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  input  logic            CTRL_START,
  input  logic            CTRL_STOP,
  input  logic [31:0]     CTRL_BASE_ADDR,
  input  logic [31:0]     CTRL_STRIDE,
  input  logic [31:0]     CTRL_FRAME_BYTES,
  input  logic [31:0]     CTRL_NFRAMES,
  output logic            WR_CONFIG_VALID,
  input  logic            WR_CONFIG_READY,
  output logic [31:0]     WR_CONFIG_START_ADDR,
  output logic [31:0]     WR_CONFIG_NBYTES,
  input  logic            AXI_BVALID,
  input  logic            AXI_BREADY,
  input  logic [1:0]      AXI_BRESP,
  output logic            BUSY,
  output logic            FRAME_DONE,
  output logic [IDXW-1:0] DONE_BUF,
  output logic [31:0]     FRAMES_WRITTEN,
  output logic            RUN_DONE,
  output logic            ERR
);

  sched_state_e          state_q, state_d;
  logic [31:0]           base_q, stride_q, nframes_q;
  logic [NBURST_W-1:0]   nbursts_q;
  logic [NBURST_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                  stop_q, stop_d;
  logic                  err_q, err_d;
  logic [31:0]           frames_q, frames_d;
  logic                  frame_done_q, frame_done_d;
  logic                  run_done_q, run_done_d;
  logic [IDXW-1:0]       done_buf_q, done_buf_d;

  logic                  start_ok;
  logic [NBURST_W-1:0]   start_nbursts;
  logic                  beat;
  logic [NBURST_W-1:0]   beat_sum;
  logic                  stop_now;
  logic                  cfg_fire;
  logic                  ring_load, ring_advance;
  logic [31:0]           ring_base;
  logic [IDXW-1:0]       ring_idx;
  logic [31:0]           ring_addr;
  logic                  unused_bytes_lsb;

  assign unused_bytes_lsb = ^CTRL_FRAME_BYTES[BURST_SHIFT-1:0];

  assign start_ok      = (state_q == ST_IDLE) && CTRL_START;
  assign start_nbursts = CTRL_FRAME_BYTES[31:BURST_SHIFT];
  assign beat          = (state_q != ST_IDLE) && AXI_BVALID && AXI_BREADY;
  assign beat_sum      = beat_cnt_q + NBURST_W'(beat);
  assign stop_now      = stop_q || CTRL_STOP;
  // The writer never handshakes back, so VALID only goes out while READY is high.
  assign cfg_fire      = (state_q == ST_ISSUE) && !stop_now && WR_CONFIG_READY;

  // Base is muxed so the load cycle sees the new value before base_q latches it.
  assign ring_base = ring_load ? CTRL_BASE_ADDR : base_q;

  dram_ring_addr_gen #(
    .NBUF (NBUF),
    .IDXW (IDXW)
  ) u_ring (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .load_i    (ring_load),
    .advance_i (ring_advance),
    .base_i    (ring_base),
    .stride_i  (stride_q),
    .idx_o     (ring_idx),
    .addr_o    (ring_addr)
  );

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    stop_d       = stop_q;
    err_d        = err_q;
    frames_d     = frames_q;
    frame_done_d = 1'b0;
    run_done_d   = 1'b0;
    done_buf_d   = done_buf_q;
    ring_load    = 1'b0;
    ring_advance = 1'b0;

    if (beat && (AXI_BRESP != AXI_RESP_OKAY)) err_d = 1'b1;
    if ((state_q != ST_IDLE) && CTRL_STOP) stop_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (CTRL_START) begin
          err_d      = (start_nbursts == '0);
          frames_d   = '0;
          beat_cnt_d = '0;
          stop_d     = 1'b0;
          ring_load  = 1'b1;
          if (start_nbursts != '0) state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        beat_cnt_d = beat_sum;
        if (stop_now) begin
          state_d    = ST_IDLE;
          run_done_d = 1'b1;
          stop_d     = 1'b0;
        end else if (WR_CONFIG_READY) begin
          state_d    = ST_WAIT_B;
          beat_cnt_d = NBURST_W'(beat);
        end
      end
      ST_WAIT_B: begin
        beat_cnt_d = beat_sum;
        if (beat_sum == nbursts_q) begin
          state_d      = ST_NEXT;
          frame_done_d = 1'b1;
          done_buf_d   = ring_idx;
          if (frames_q != '1) frames_d = frames_q + 32'd1;
        end
      end
      ST_NEXT: begin
        beat_cnt_d   = beat_sum;
        ring_advance = 1'b1;
        // frames_q already includes the frame just completed.
        if (stop_now || ((nframes_q != '0) && (frames_q == nframes_q))) begin
          state_d    = ST_IDLE;
          run_done_d = 1'b1;
          stop_d     = 1'b0;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      stride_q     <= '0;
      nframes_q    <= '0;
      nbursts_q    <= '0;
      beat_cnt_q   <= '0;
      stop_q       <= 1'b0;
      err_q        <= 1'b0;
      frames_q     <= '0;
      frame_done_q <= 1'b0;
      run_done_q   <= 1'b0;
      done_buf_q   <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      stop_q       <= stop_d;
      err_q        <= err_d;
      frames_q     <= frames_d;
      frame_done_q <= frame_done_d;
      run_done_q   <= run_done_d;
      done_buf_q   <= done_buf_d;
      if (start_ok) begin
        base_q    <= CTRL_BASE_ADDR;
        stride_q  <= CTRL_STRIDE;
        nframes_q <= CTRL_NFRAMES;
        nbursts_q <= start_nbursts;
      end
    end
  end

  assign WR_CONFIG_VALID      = cfg_fire;
  assign WR_CONFIG_START_ADDR = ring_addr;
  assign WR_CONFIG_NBYTES     = {nbursts_q, {BURST_SHIFT{1'b0}}};
  assign BUSY                 = (state_q != ST_IDLE);
  assign FRAME_DONE           = frame_done_q;
  assign DONE_BUF             = done_buf_q;
  assign FRAMES_WRITTEN       = frames_q;
  assign RUN_DONE             = run_done_q;
  assign ERR                  = err_q;

endmodule

// File: tb/tb_dram_write_scheduler.sv
// Scoreboard bench for dram_write_scheduler with a simple writer/B-channel model.
module tb_dram_write_scheduler;
  import dram_write_scheduler_pkg::*;

  localparam int NBUF = 3;
  localparam int IDXW = 4;

  logic            ACLK = 1'b0;
  logic            ARESETN;
  logic            CTRL_START, CTRL_STOP;
  logic [31:0]     CTRL_BASE_ADDR, CTRL_STRIDE, CTRL_FRAME_BYTES, CTRL_NFRAMES;
  logic            WR_CONFIG_VALID, WR_CONFIG_READY;
  logic [31:0]     WR_CONFIG_START_ADDR, WR_CONFIG_NBYTES;
  logic            AXI_BVALID, AXI_BREADY;
  logic [1:0]      AXI_BRESP;
  logic            BUSY, FRAME_DONE, RUN_DONE, ERR;
  logic [IDXW-1:0] DONE_BUF;
  logic [31:0]     FRAMES_WRITTEN;

  dram_write_scheduler #(.NBUF(NBUF), .IDXW(IDXW)) dut (
    .ACLK                 (ACLK),
    .ARESETN              (ARESETN),
    .CTRL_START           (CTRL_START),
    .CTRL_STOP            (CTRL_STOP),
    .CTRL_BASE_ADDR       (CTRL_BASE_ADDR),
    .CTRL_STRIDE          (CTRL_STRIDE),
    .CTRL_FRAME_BYTES     (CTRL_FRAME_BYTES),
    .CTRL_NFRAMES         (CTRL_NFRAMES),
    .WR_CONFIG_VALID      (WR_CONFIG_VALID),
    .WR_CONFIG_READY      (WR_CONFIG_READY),
    .WR_CONFIG_START_ADDR (WR_CONFIG_START_ADDR),
    .WR_CONFIG_NBYTES     (WR_CONFIG_NBYTES),
    .AXI_BVALID           (AXI_BVALID),
    .AXI_BREADY           (AXI_BREADY),
    .AXI_BRESP            (AXI_BRESP),
    .BUSY                 (BUSY),
    .FRAME_DONE           (FRAME_DONE),
    .DONE_BUF             (DONE_BUF),
    .FRAMES_WRITTEN       (FRAMES_WRITTEN),
    .RUN_DONE             (RUN_DONE),
    .ERR                  (ERR)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_nb[$];
  int          exp_buf[$];
  int          jobs[$];

  int n_valid = 0, n_fd = 0, n_rd = 0;
  int cur_left = 0, beat_no = 0, bad_beat = -1;
  logic prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Reference ring walk: expected configs and completed indices for a run.
  task automatic push_run(input logic [31:0] base, input logic [31:0] stride,
                          input logic [31:0] bytes, input int nfr);
    logic [31:0] a;
    int idx;
    a = base;
    idx = 0;
    for (int i = 0; i < nfr; i++) begin
      exp_addr.push_back(a);
      exp_nb.push_back(bytes);
      exp_buf.push_back(idx);
      if (idx == NBUF - 1) begin
        idx = 0;
        a = base;
      end else begin
        idx++;
        a = a + stride;
      end
    end
  endtask

  task automatic start_run(input logic [31:0] base, input logic [31:0] stride,
                           input logic [31:0] bytes, input logic [31:0] nfr,
                           input logic with_stop);
    CTRL_BASE_ADDR   = base;
    CTRL_STRIDE      = stride;
    CTRL_FRAME_BYTES = bytes;
    CTRL_NFRAMES     = nfr;
    CTRL_START       = 1'b1;
    CTRL_STOP        = with_stop;
    step();
    CTRL_START = 1'b0;
    CTRL_STOP  = 1'b0;
  endtask

  task automatic wait_run(input string tag, input int budget);
    int r0, n;
    r0 = n_rd;
    n = 0;
    while (n_rd == r0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, (n_rd != r0), 1);
  endtask

  task automatic wait_valid(input int target, input int budget);
    int n;
    n = 0;
    while (n_valid < target && n < budget) begin
      step();
      n++;
    end
    chk("cfg_arrival", (n_valid >= target), 1);
  endtask

  task automatic check_queues_empty();
    chk("cfg_all_seen", exp_addr.size(), 0);
    chk("frames_all_seen", exp_buf.size(), 0);
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      prev_valid = 1'b0;
    end else begin
      if (WR_CONFIG_VALID) begin
        n_valid++;
        chk("valid_with_ready", WR_CONFIG_READY, 1);
        chk("valid_one_cycle", prev_valid, 0);
        chk("cfg_was_expected", (exp_addr.size() != 0), 1);
        if (exp_addr.size() != 0) begin
          chk("cfg_addr", WR_CONFIG_START_ADDR, exp_addr.pop_front());
          chk("cfg_nbytes", WR_CONFIG_NBYTES, exp_nb.pop_front());
        end
        jobs.push_back(int'(WR_CONFIG_NBYTES >> BURST_SHIFT));
      end
      prev_valid = WR_CONFIG_VALID;
      if (FRAME_DONE) begin
        n_fd++;
        chk("frame_was_expected", (exp_buf.size() != 0), 1);
        if (exp_buf.size() != 0) chk("done_buf", DONE_BUF, exp_buf.pop_front());
      end
      if (RUN_DONE) n_rd++;
    end
  end

  // Writer model: after each config, returns nbursts back-to-back B beats.
  initial begin
    AXI_BVALID = 1'b0;
    AXI_BRESP  = 2'b00;
    forever begin
      @(posedge ACLK);
      #2;
      AXI_BVALID = 1'b0;
      AXI_BRESP  = 2'b00;
      if (!ARESETN) begin
        jobs.delete();
        cur_left = 0;
      end else if (cur_left > 0) begin
        AXI_BVALID = 1'b1;
        AXI_BRESP  = (beat_no == bad_beat) ? 2'b10 : 2'b00;
        beat_no++;
        cur_left--;
      end else if (jobs.size() != 0) begin
        cur_left = jobs.pop_front();
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, fd0, r0;
    ARESETN          = 1'b0;
    CTRL_START       = 1'b0;
    CTRL_STOP        = 1'b0;
    CTRL_BASE_ADDR   = '0;
    CTRL_STRIDE      = '0;
    CTRL_FRAME_BYTES = '0;
    CTRL_NFRAMES     = '0;
    WR_CONFIG_READY  = 1'b1;
    AXI_BREADY       = 1'b1;
    step();
    step();
    chk("rst_busy", BUSY, 0);
    chk("rst_valid", WR_CONFIG_VALID, 0);
    chk("rst_frames", FRAMES_WRITTEN, 0);
    chk("rst_err", ERR, 0);
    chk("rst_done_buf", DONE_BUF, 0);
    chk("rst_addr", WR_CONFIG_START_ADDR, 0);
    ARESETN = 1'b1;
    step();

    // 4 frames over a 3-buffer ring; a START while busy must be ignored.
    fd0 = n_fd;
    push_run(32'h1000_0000, 32'h0001_0000, 32'd512, 4);
    v0 = n_valid;
    start_run(32'h1000_0000, 32'h0001_0000, 32'd512, 32'd4, 1'b0);
    chk("busy_after_start", BUSY, 1);
    wait_valid(v0 + 1, 50);
    CTRL_BASE_ADDR = 32'hDEAD_0000;
    CTRL_START = 1'b1;
    step();
    CTRL_START = 1'b0;
    wait_run("run4_done", 200);
    chk("run4_frames", FRAMES_WRITTEN, 4);
    chk("run4_frame_pulses", n_fd - fd0, 4);
    chk("run4_idle", BUSY, 0);
    chk("run4_err", ERR, 0);
    check_queues_empty();

    // Zero bursts: error, no traffic.
    v0 = n_valid;
    start_run(32'h2000_0000, 32'h100, 32'd100, 32'd1, 1'b0);
    chk("zero_err", ERR, 1);
    chk("zero_busy", BUSY, 0);
    repeat (5) step();
    chk("zero_busy_later", BUSY, 0);
    chk("zero_no_cfg", n_valid - v0, 0);

    // Error response on 2nd beat of frame 1; both frames still complete.
    push_run(32'h3000_0000, 32'h0000_1000, 32'd512, 2);
    bad_beat = beat_no + 1;
    start_run(32'h3000_0000, 32'h0000_1000, 32'd512, 32'd2, 1'b0);
    chk("bresp_start_clears_err", ERR, 0);
    wait_run("bresp_run_done", 200);
    chk("bresp_err_sticky", ERR, 1);
    chk("bresp_frames", FRAMES_WRITTEN, 2);
    check_queues_empty();
    bad_beat = -1;
    push_run(32'h3100_0000, 32'h0, 32'd128, 1);
    start_run(32'h3100_0000, 32'h0, 32'd128, 32'd1, 1'b0);
    chk("restart_clears_err", ERR, 0);
    wait_run("restart_done", 100);
    chk("one_burst_frames", FRAMES_WRITTEN, 1);

    // Continuous run, stop during WAIT_B of frame 2.
    push_run(32'h4000_0000, 32'h0000_0800, 32'd512, 2);
    v0 = n_valid;
    start_run(32'h4000_0000, 32'h0000_0800, 32'd512, 32'd0, 1'b0);
    wait_valid(v0 + 2, 100);
    CTRL_STOP = 1'b1;
    step();
    CTRL_STOP = 1'b0;
    chk("stop_still_busy", BUSY, 1);
    wait_run("stop_run_done", 100);
    chk("stop_frames", FRAMES_WRITTEN, 2);
    chk("stop_last_buf", DONE_BUF, 1);
    check_queues_empty();

    // READY held low 10 cycles in ISSUE; START with STOP in IDLE -> START wins.
    WR_CONFIG_READY = 1'b0;
    push_run(32'h5000_0000, 32'h0, 32'd256, 1);
    v0 = n_valid;
    start_run(32'h5000_0000, 32'h0, 32'd256, 32'd1, 1'b1);
    repeat (10) step();
    chk("ready_low_no_cfg", n_valid - v0, 0);
    chk("ready_low_busy", BUSY, 1);
    WR_CONFIG_READY = 1'b1;
    wait_run("ready_run_done", 100);
    chk("ready_one_cfg", n_valid - v0, 1);
    chk("ready_frames", FRAMES_WRITTEN, 1);
    check_queues_empty();

    // Stop in ISSUE before any config: run ends with no frame.
    WR_CONFIG_READY = 1'b0;
    v0 = n_valid;
    start_run(32'h6000_0000, 32'h0, 32'd512, 32'd3, 1'b0);
    step();
    CTRL_STOP = 1'b1;
    step();
    CTRL_STOP = 1'b0;
    wait_run("issue_stop_done", 20);
    chk("issue_stop_no_cfg", n_valid - v0, 0);
    chk("issue_stop_frames", FRAMES_WRITTEN, 0);
    chk("issue_stop_idle", BUSY, 0);
    WR_CONFIG_READY = 1'b1;

    // Reset during WAIT_B: everything clears, no RUN_DONE; then a clean run.
    push_run(32'h7000_0000, 32'h100, 32'd512, 3);
    v0 = n_valid;
    start_run(32'h7000_0000, 32'h100, 32'd512, 32'd3, 1'b0);
    wait_valid(v0 + 1, 50);
    step();
    r0 = n_rd;
    ARESETN = 1'b0;
    step();
    chk("arst_busy", BUSY, 0);
    chk("arst_valid", WR_CONFIG_VALID, 0);
    chk("arst_frame_done", FRAME_DONE, 0);
    chk("arst_run_done", RUN_DONE, 0);
    chk("arst_frames", FRAMES_WRITTEN, 0);
    chk("arst_addr", WR_CONFIG_START_ADDR, 0);
    chk("arst_nbytes", WR_CONFIG_NBYTES, 0);
    step();
    step();
    exp_addr.delete();
    exp_nb.delete();
    exp_buf.delete();
    ARESETN = 1'b1;
    step();
    step();
    chk("arst_no_run_done", n_rd - r0, 0);
    push_run(32'h8000_0000, 32'h0002_0000, 32'd384, 2);
    start_run(32'h8000_0000, 32'h0002_0000, 32'd384, 32'd2, 1'b0);
    wait_run("post_rst_done", 100);
    chk("post_rst_frames", FRAMES_WRITTEN, 2);
    check_queues_empty();

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dram_write_scheduler.md
Name: dram_write_scheduler

Overview:
Sequencing controller in front of the AXI DRAM writer block. Turns one software-level "capture N frames into a ring of NBUF buffers" command into a series of single-frame writer configurations. Counts write responses to confirm each frame has landed in DRAM, then publishes the completed buffer index to downstream readers. Sits between the control/register interface and the writer's CONFIG port, and snoops the writer's AXI B channel.

Parameters:
NBUF, 3, number of ring buffers (1..16)
IDXW, 4, width of buffer index; must satisfy 2^IDXW >= NBUF

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous active-low reset
CTRL_START  in  1  one-cycle pulse; starts a run; ignored unless idle
CTRL_STOP  in  1  one-cycle pulse; finish current frame, then idle
CTRL_BASE_ADDR  in  32  address of buffer 0; sampled on start
CTRL_STRIDE  in  32  byte distance between buffers; sampled on start
CTRL_FRAME_BYTES  in  32  bytes per frame; multiple of 128; sampled on start
CTRL_NFRAMES  in  32  frames to write; 0 = run until stopped; sampled on start
WR_CONFIG_VALID  out  1  to writer CONFIG_VALID
WR_CONFIG_READY  in  1  from writer CONFIG_READY
WR_CONFIG_START_ADDR  out  32  to writer CONFIG_START_ADDR
WR_CONFIG_NBYTES  out  32  to writer CONFIG_NBYTES
AXI_BVALID  in  1  snooped M_AXI_BVALID
AXI_BREADY  in  1  snooped M_AXI_BREADY
AXI_BRESP  in  2  snooped M_AXI_BRESP
BUSY  out  1  high whenever state != IDLE
FRAME_DONE  out  1  one-cycle pulse per completed frame
DONE_BUF  out  IDXW  index of the last completed buffer; valid from the FRAME_DONE cycle onward
FRAMES_WRITTEN  out  32  completed frames in the current run
RUN_DONE  out  1  one-cycle pulse when a run ends, whether by count or by stop
ERR  out  1  sticky; cleared by CTRL_START

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; internal index, address and counters 0.
  - Reset mid-run aborts immediately; no RUN_DONE pulse. The writer is reset on the same ARESETN.
- Start and configuration:
  - nbursts = CTRL_FRAME_BYTES[31:7], latched on start.
  - If nbursts == 0 at start: set ERR, stay IDLE, no writer traffic.
- States:
  - IDLE: on CTRL_START, latch inputs, clear ERR, FRAMES_WRITTEN, index and burst count, load cur_addr = base, go ISSUE.
  - ISSUE: wait for WR_CONFIG_READY=1.
    - On that cycle, assert WR_CONFIG_VALID for exactly one cycle with START_ADDR = cur_addr and NBYTES = {nbursts, 7'b0}.
    - Next cycle go WAIT_B.
    - WR_CONFIG_VALID is never asserted while WR_CONFIG_READY=0. The writer does not handshake, so the one-cycle VALID is the contract.
  - WAIT_B: count beats where AXI_BVALID && AXI_BREADY.
    - When the count reaches nbursts (including the beat arriving this cycle), go NEXT.
    - Any beat with BRESP != 0 sets ERR; the frame still completes.
  - NEXT (1 cycle):
    - Pulse FRAME_DONE; DONE_BUF <= index; FRAMES_WRITTEN += 1.
    - Advance the ring: if index == NBUF-1 then index = 0 and cur_addr = base; else index += 1 and cur_addr += stride. Addresses wrap modulo 2^32.
    - If a stop is pending, or NFRAMES != 0 and FRAMES_WRITTEN+1 == NFRAMES: pulse RUN_DONE and go IDLE. Otherwise go ISSUE.
- B-beat counting:
  - Beats are counted only in ISSUE, WAIT_B and NEXT.
  - The count clears on the transition into WAIT_B, but preserves a beat that arrives on that same cycle.
  - A beat seen in IDLE is ignored.
- Stop:
  - CTRL_STOP in any non-IDLE state sets stop_pending; in IDLE it is ignored.
  - Stop in ISSUE before VALID is sent: go IDLE with a RUN_DONE pulse and no frame issued.
  - Stop and START in the same cycle while IDLE: START wins, stop ignored.
  - CTRL_START while busy is ignored.
- Throughput and latency:
  - Minimum inter-frame gap is 2 cycles of scheduler overhead (NEXT, then ISSUE) beyond the writer's own CONFIG_READY latency.
  - FRAME_DONE fires 1 cycle after the final B beat.
- Width rules:
  - FRAMES_WRITTEN saturates at 2^32-1 in continuous mode.
  - The burst counter is 25 bits.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, ISSUE, WAIT_B, NEXT)
  - BURST_BYTES=128 and BURST_SHIFT=7, shared with the writer
  - AXI_RESP_OKAY=2'b00
- One natural sub-module: dram_ring_addr_gen. It holds index and cur_addr, with load/advance inputs and base/stride/NBUF wrap.

Test Plan:
- NBUF=3, base=0x1000_0000, stride=0x1_0000, bytes=512, nframes=4; writer model returns 4 OKAY B beats per frame -> 4 configs at 0x1000_0000, 0x1001_0000, 0x1002_0000, 0x1000_0000, each NBYTES=512; DONE_BUF sequence 0,1,2,0; RUN_DONE after 4th FRAME_DONE; FRAMES_WRITTEN=4.
- bytes=100 (nbursts=0) with START -> ERR=1, BUSY stays 0, no WR_CONFIG_VALID.
- nframes=0, stop pulsed mid WAIT_B of frame 2 -> frame 2 completes (FRAME_DONE, DONE_BUF=1), then RUN_DONE, IDLE, FRAMES_WRITTEN=2.
- Hold WR_CONFIG_READY low for 10 cycles in ISSUE -> no VALID until READY=1, then exactly one VALID cycle.
- One B beat with BRESP=2'b10 in frame 1 of a 2-frame run -> ERR sticky 1, both frames complete; next START clears ERR.
- ARESETN low during WAIT_B -> all outputs 0 next cycle, no RUN_DONE; subsequent START runs normally.
